// File: rtl/exp_gain_apply.sv
// Applies the 1.8 fixed-point exposure gain to an RGB pixel stream, delaying pixels to align with the curve stage.
// Optional per-frame clipped-pixel statistics are built when CLIP_STAT_EN is defined.
module exp_gain_apply #(
    parameter int DW_PIX    = 8,
    parameter int DW_Y      = 9,
    parameter int CURVE_LAT = 2
`ifdef CLIP_STAT_EN
    , parameter int DW_CNT  = 22
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic              in_sof,
    input  logic              in_eol,
    input  logic [DW_PIX-1:0] in_r,
    input  logic [DW_PIX-1:0] in_g,
    input  logic [DW_PIX-1:0] in_b,
    input  logic [DW_Y-1:0]   gain,
    input  logic              bypass,
    output logic              out_vld,
    output logic              out_sof,
    output logic              out_eol,
    output logic [DW_PIX-1:0] out_r,
    output logic [DW_PIX-1:0] out_g,
    output logic [DW_PIX-1:0] out_b,
    output logic              out_clip
`ifdef CLIP_STAT_EN
    ,
    output logic [DW_CNT-1:0] frame_clip_cnt,
    output logic              frame_clip_vld
`endif
);

    localparam int FRAC = DW_Y - 1;
    localparam int PW   = DW_PIX + DW_Y;
    localparam logic [PW-1:0]        RND     = {{(PW-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic [PW-FRAC-1:0]   PIX_MAX = {1'b0, {DW_PIX{1'b1}}};

    logic [CURVE_LAT-1:0] d_vld, d_sof, d_eol;
    logic [DW_PIX-1:0]    d_r [CURVE_LAT];
    logic [DW_PIX-1:0]    d_g [CURVE_LAT];
    logic [DW_PIX-1:0]    d_b [CURVE_LAT];

    // Framing flags are qualified on entry so invalid slots never carry stale sof/eol.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_vld <= '0;
            d_sof <= '0;
            d_eol <= '0;
            for (int i = 0; i < CURVE_LAT; i++) begin
                d_r[i] <= '0;
                d_g[i] <= '0;
                d_b[i] <= '0;
            end
        end else begin
            d_vld[0] <= in_vld;
            d_sof[0] <= in_vld & in_sof;
            d_eol[0] <= in_vld & in_eol;
            d_r[0]   <= in_r;
            d_g[0]   <= in_g;
            d_b[0]   <= in_b;
            for (int i = 1; i < CURVE_LAT; i++) begin
                d_vld[i] <= d_vld[i-1];
                d_sof[i] <= d_sof[i-1];
                d_eol[i] <= d_eol[i-1];
                d_r[i]   <= d_r[i-1];
                d_g[i]   <= d_g[i-1];
                d_b[i]   <= d_b[i-1];
            end
        end
    end

    logic [PW-1:0] prod_r, prod_g, prod_b;

    always_comb begin
        prod_r = PW'(d_r[CURVE_LAT-1]) * PW'(gain);
        prod_g = PW'(d_g[CURVE_LAT-1]) * PW'(gain);
        prod_b = PW'(d_b[CURVE_LAT-1]) * PW'(gain);
    end

    logic              m_vld, m_sof, m_eol, m_byp;
    logic [PW-1:0]     m_rnd_r, m_rnd_g, m_rnd_b;
    logic [DW_PIX-1:0] m_pix_r, m_pix_g, m_pix_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_vld   <= 1'b0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            m_byp   <= 1'b0;
            m_rnd_r <= '0;
            m_rnd_g <= '0;
            m_rnd_b <= '0;
            m_pix_r <= '0;
            m_pix_g <= '0;
            m_pix_b <= '0;
        end else begin
            m_vld   <= d_vld[CURVE_LAT-1];
            m_sof   <= d_sof[CURVE_LAT-1];
            m_eol   <= d_eol[CURVE_LAT-1];
            m_byp   <= bypass;
            m_rnd_r <= prod_r + RND;
            m_rnd_g <= prod_g + RND;
            m_rnd_b <= prod_b + RND;
            m_pix_r <= d_r[CURVE_LAT-1];
            m_pix_g <= d_g[CURVE_LAT-1];
            m_pix_b <= d_b[CURVE_LAT-1];
        end
    end

    logic [PW-FRAC-1:0] res_r, res_g, res_b;
    logic               clip_r, clip_g, clip_b;
    logic [DW_PIX-1:0]  sat_r, sat_g, sat_b;

    always_comb begin
        res_r  = m_rnd_r[PW-1:FRAC];
        res_g  = m_rnd_g[PW-1:FRAC];
        res_b  = m_rnd_b[PW-1:FRAC];
        clip_r = res_r > PIX_MAX;
        clip_g = res_g > PIX_MAX;
        clip_b = res_b > PIX_MAX;
        sat_r  = clip_r ? {DW_PIX{1'b1}} : res_r[DW_PIX-1:0];
        sat_g  = clip_g ? {DW_PIX{1'b1}} : res_g[DW_PIX-1:0];
        sat_b  = clip_b ? {DW_PIX{1'b1}} : res_b[DW_PIX-1:0];
    end

    // Pixel data holds its last value across gaps; flags are forced low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_sof  <= 1'b0;
            out_eol  <= 1'b0;
            out_clip <= 1'b0;
            out_r    <= '0;
            out_g    <= '0;
            out_b    <= '0;
        end else begin
            out_vld  <= m_vld;
            out_sof  <= m_vld & m_sof;
            out_eol  <= m_vld & m_eol;
            out_clip <= m_vld & ~m_byp & (clip_r | clip_g | clip_b);
            if (m_vld) begin
                out_r <= m_byp ? m_pix_r : sat_r;
                out_g <= m_byp ? m_pix_g : sat_g;
                out_b <= m_byp ? m_pix_b : sat_b;
            end
        end
    end

`ifdef CLIP_STAT_EN
    localparam logic [DW_CNT-1:0] CNT_MAX = {DW_CNT{1'b1}};

    logic [DW_CNT-1:0] clip_acc;

    // A new frame restarts the count with its own first pixel's clip bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_acc       <= '0;
            frame_clip_cnt <= '0;
            frame_clip_vld <= 1'b0;
        end else begin
            frame_clip_vld <= 1'b0;
            if (out_vld && out_sof) begin
                frame_clip_cnt <= clip_acc;
                frame_clip_vld <= 1'b1;
                clip_acc       <= DW_CNT'(out_clip);
            end else if (out_vld && out_clip && clip_acc != CNT_MAX) begin
                clip_acc <= clip_acc + DW_CNT'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_exp_gain_apply.sv
// Self-checking bench for exp_gain_apply: directed spot values plus randomized streams against an arithmetic model.
module tb_exp_gain_apply;

    localparam int NMAX = 72;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_vld, in_sof, in_eol;
    logic [7:0] in_r, in_g, in_b;
    logic [8:0] gain;
    logic       bypass;
    logic       out_vld, out_sof, out_eol, out_clip;
    logic [7:0] out_r, out_g, out_b;
`ifdef CLIP_STAT_EN
    logic [21:0] frame_clip_cnt;
    logic        frame_clip_vld;
`endif

    exp_gain_apply dut (
        .clk            (clk),
        .rst            (rst),
        .in_vld         (in_vld),
        .in_sof         (in_sof),
        .in_eol         (in_eol),
        .in_r           (in_r),
        .in_g           (in_g),
        .in_b           (in_b),
        .gain           (gain),
        .bypass         (bypass),
        .out_vld        (out_vld),
        .out_sof        (out_sof),
        .out_eol        (out_eol),
        .out_r          (out_r),
        .out_g          (out_g),
        .out_b          (out_b),
        .out_clip       (out_clip)
`ifdef CLIP_STAT_EN
        ,
        .frame_clip_cnt (frame_clip_cnt),
        .frame_clip_vld (frame_clip_vld)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit         st_vld [NMAX];
    bit         st_sof [NMAX];
    bit         st_eol [NMAX];
    bit         st_byp [NMAX];
    logic [7:0] st_r   [NMAX];
    logic [7:0] st_g   [NMAX];
    logic [7:0] st_b   [NMAX];
    logic [8:0] st_gain[NMAX];

    logic       ob_vld [NMAX];
    logic       ob_sof [NMAX];
    logic       ob_eol [NMAX];
    logic       ob_clip[NMAX];
    logic [7:0] ob_r   [NMAX];
    logic [7:0] ob_g   [NMAX];
    logic [7:0] ob_b   [NMAX];
`ifdef CLIP_STAT_EN
    logic        ob_fcv[NMAX];
    logic [21:0] ob_fcc[NMAX];
`endif

    // Reference: round-half-up of pix*gain/256, clamped to 255.
    function automatic int mdl_raw(input int pix, input int g);
        return (pix * g + 128) / 256;
    endfunction

    function automatic int mdl_val(input int pix, input int g, input bit byp);
        int v;
        if (byp) return pix;
        v = mdl_raw(pix, g);
        return (v > 255) ? 255 : v;
    endfunction

    // Drive n pixels from the st_* tables; gain/bypass follow their pixel by two clocks.
    task automatic run_stream(input int n);
        for (int k = 0; k < n + 6; k++) begin
            if (k < n) begin
                in_vld = st_vld[k];
                in_sof = st_sof[k];
                in_eol = st_eol[k];
                in_r   = st_r[k];
                in_g   = st_g[k];
                in_b   = st_b[k];
            end else begin
                in_vld = 1'b0;
                in_sof = 1'b0;
                in_eol = 1'b0;
                in_r   = 8'($urandom_range(0, 255));
                in_g   = 8'($urandom_range(0, 255));
                in_b   = 8'($urandom_range(0, 255));
            end
            if (k >= 2 && k - 2 < n) begin
                gain   = st_gain[k-2];
                bypass = st_byp[k-2];
            end else begin
                gain   = 9'($urandom_range(0, 511));
            end
            @(posedge clk);
            #1;
            if (k >= 3) begin
                ob_vld[k-3]  = out_vld;
                ob_sof[k-3]  = out_sof;
                ob_eol[k-3]  = out_eol;
                ob_clip[k-3] = out_clip;
                ob_r[k-3]    = out_r;
                ob_g[k-3]    = out_g;
                ob_b[k-3]    = out_b;
`ifdef CLIP_STAT_EN
                ob_fcv[k-3]  = frame_clip_vld;
                ob_fcc[k-3]  = frame_clip_cnt;
`endif
            end
        end
    endtask

    task automatic do_reset();
        in_vld = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
        in_r = 8'd0; in_g = 8'd0; in_b = 8'd0;
        gain = 9'd0; bypass = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        in_vld = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
        in_r = 8'd0; in_g = 8'd0; in_b = 8'd0;
        gain = 9'd0; bypass = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({out_vld, out_sof, out_eol, out_clip, out_r, out_g, out_b} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got vld=%b sof=%b eol=%b clip=%b rgb=%0d/%0d/%0d, want all 0",
                     out_vld, out_sof, out_eol, out_clip, out_r, out_g, out_b);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_vld: got %b, want 0", out_vld);
        end
    endtask

    task automatic test_unity();
        in_vld = 1'b1; in_sof = 1'b0; in_eol = 1'b0;
        in_r = 8'd100; in_g = 8'd0; in_b = 8'd255;
        gain = 9'd256; bypass = 1'b0;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (c < 4) begin
                n_checks++;
                if (out_vld !== 1'b0) begin
                    n_fail++;
                    $display("FAIL unity_early_vld: clock %0d got %b, want 0", c, out_vld);
                end
            end
        end
        n_checks++;
        if ({out_vld, out_clip, out_r, out_g, out_b} !== {1'b1, 1'b0, 8'd100, 8'd0, 8'd255}) begin
            n_fail++;
            $display("FAIL unity_gain: got vld=%b clip=%b rgb=%0d/%0d/%0d, want 1 0 100/0/255",
                     out_vld, out_clip, out_r, out_g, out_b);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_rounding();
        st_vld[0] = 1; st_sof[0] = 0; st_eol[0] = 0; st_byp[0] = 0;
        st_r[0] = 8'd3; st_g[0] = 8'd1; st_b[0] = 8'd255; st_gain[0] = 9'd128;
        run_stream(1);
        n_checks++;
        if ({ob_vld[0], ob_clip[0], ob_r[0], ob_g[0], ob_b[0]} !== {1'b1, 1'b0, 8'd2, 8'd1, 8'd128}) begin
            n_fail++;
            $display("FAIL rounding: got vld=%b clip=%b rgb=%0d/%0d/%0d, want 1 0 2/1/128",
                     ob_vld[0], ob_clip[0], ob_r[0], ob_g[0], ob_b[0]);
        end
        n_checks++;
        if ({ob_vld[1], ob_vld[2]} !== 2'b00) begin
            n_fail++;
            $display("FAIL rounding_single: got trailing vld=%b%b, want 00", ob_vld[1], ob_vld[2]);
        end
    endtask

    task automatic test_saturation();
        logic [24:0] want [3];
        for (int i = 0; i < 3; i++) begin
            st_vld[i] = 1; st_sof[i] = 0; st_eol[i] = 0; st_byp[i] = 0;
        end
        st_r[0] = 8'd200; st_g[0] = 8'd170; st_b[0] = 8'd10;  st_gain[0] = 9'd384;
        st_r[1] = 8'd255; st_g[1] = 8'd255; st_b[1] = 8'd255; st_gain[1] = 9'd511;
        st_r[2] = 8'd37;  st_g[2] = 8'd200; st_b[2] = 8'd255; st_gain[2] = 9'd0;
        want[0] = {1'b1, 8'd255, 8'd255, 8'd15};
        want[1] = {1'b1, 8'd255, 8'd255, 8'd255};
        want[2] = {1'b0, 8'd0,   8'd0,   8'd0};
        run_stream(3);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({ob_vld[i], ob_clip[i], ob_r[i], ob_g[i], ob_b[i]} !== {1'b1, want[i]}) begin
                n_fail++;
                $display("FAIL saturation[%0d]: got vld=%b clip=%b rgb=%0d/%0d/%0d, want 1 %b %0d/%0d/%0d",
                         i, ob_vld[i], ob_clip[i], ob_r[i], ob_g[i], ob_b[i],
                         want[i][24], want[i][23:16], want[i][15:8], want[i][7:0]);
            end
        end
    endtask

    task automatic test_stream_gaps();
        bit pat_v [4] = '{1, 1, 0, 1};
        int er, eg, eb;
        bit ec;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) begin
                st_vld[i] = pat_v[i];
                st_sof[i] = (i == 0);
                st_eol[i] = (i == 3);
                st_byp[i] = bit'(b);
                st_r[i] = 8'($urandom_range(0, 255));
                st_g[i] = 8'($urandom_range(0, 255));
                st_b[i] = 8'($urandom_range(0, 255));
                st_gain[i] = 9'($urandom_range(256, 511));
            end
            run_stream(4);
            er = 0; eg = 0; eb = 0;
            for (int j = 0; j < 7; j++) begin
                ec = 0;
                if (j < 4 && st_vld[j]) begin
                    er = mdl_val(int'(st_r[j]), int'(st_gain[j]), st_byp[j]);
                    eg = mdl_val(int'(st_g[j]), int'(st_gain[j]), st_byp[j]);
                    eb = mdl_val(int'(st_b[j]), int'(st_gain[j]), st_byp[j]);
                    ec = !st_byp[j] && (mdl_raw(int'(st_r[j]), int'(st_gain[j])) > 255 ||
                                        mdl_raw(int'(st_g[j]), int'(st_gain[j])) > 255 ||
                                        mdl_raw(int'(st_b[j]), int'(st_gain[j])) > 255);
                end
                n_checks++;
                if ({ob_vld[j], ob_sof[j], ob_eol[j], ob_clip[j]} !==
                    {(j < 4) && st_vld[j], (j < 4) && st_vld[j] && st_sof[j],
                     (j < 4) && st_vld[j] && st_eol[j], ec}) begin
                    n_fail++;
                    $display("FAIL gaps_flags byp=%0d slot %0d: got vld/sof/eol/clip=%b%b%b%b, want %b%b%b%b",
                             b, j, ob_vld[j], ob_sof[j], ob_eol[j], ob_clip[j],
                             (j < 4) && st_vld[j], (j < 4) && st_vld[j] && st_sof[j],
                             (j < 4) && st_vld[j] && st_eol[j], ec);
                end
                n_checks++;
                if ({ob_r[j], ob_g[j], ob_b[j]} !== {8'(er), 8'(eg), 8'(eb)}) begin
                    n_fail++;
                    $display("FAIL gaps_data byp=%0d slot %0d: got %0d/%0d/%0d, want %0d/%0d/%0d",
                             b, j, ob_r[j], ob_g[j], ob_b[j], er, eg, eb);
                end
            end
        end
        bypass = 1'b0;
    endtask

    task automatic test_random();
        int n = 48;
        int er, eg, eb;
        bit ec, ev;
        for (int i = 0; i < n; i++) begin
            st_vld[i] = (i == 0) || ($urandom_range(0, 3) != 0);
            st_sof[i] = ($urandom_range(0, 7) == 0);
            st_eol[i] = ($urandom_range(0, 5) == 0);
            st_byp[i] = ((i / 16) == 1);
            st_r[i] = 8'($urandom_range(0, 255));
            st_g[i] = 8'($urandom_range(0, 255));
            st_b[i] = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 7))
                0: st_gain[i] = 9'd0;
                1: st_gain[i] = 9'd511;
                2: st_gain[i] = 9'd256;
                default: st_gain[i] = 9'($urandom_range(0, 511));
            endcase
        end
        run_stream(n);
        er = 0; eg = 0; eb = 0;
        for (int j = 0; j < n; j++) begin
            ev = st_vld[j];
            ec = 0;
            if (ev) begin
                er = mdl_val(int'(st_r[j]), int'(st_gain[j]), st_byp[j]);
                eg = mdl_val(int'(st_g[j]), int'(st_gain[j]), st_byp[j]);
                eb = mdl_val(int'(st_b[j]), int'(st_gain[j]), st_byp[j]);
                ec = !st_byp[j] && (mdl_raw(int'(st_r[j]), int'(st_gain[j])) > 255 ||
                                    mdl_raw(int'(st_g[j]), int'(st_gain[j])) > 255 ||
                                    mdl_raw(int'(st_b[j]), int'(st_gain[j])) > 255);
            end
            n_checks++;
            if ({ob_vld[j], ob_sof[j], ob_eol[j], ob_clip[j]} !==
                {ev, ev && st_sof[j], ev && st_eol[j], ec}) begin
                n_fail++;
                $display("FAIL random_flags slot %0d: got vld/sof/eol/clip=%b%b%b%b, want %b%b%b%b",
                         j, ob_vld[j], ob_sof[j], ob_eol[j], ob_clip[j],
                         ev, ev && st_sof[j], ev && st_eol[j], ec);
            end
            n_checks++;
            if ({ob_r[j], ob_g[j], ob_b[j]} !== {8'(er), 8'(eg), 8'(eb)}) begin
                n_fail++;
                $display("FAIL random_data slot %0d: got %0d/%0d/%0d, want %0d/%0d/%0d (gain %0d byp %0d)",
                         j, ob_r[j], ob_g[j], ob_b[j], er, eg, eb, st_gain[j], st_byp[j]);
            end
        end
        bypass = 1'b0;
    endtask

    task automatic test_reset_midstream();
        gain = 9'd256; bypass = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_vld = 1'b1; in_sof = (i == 0); in_eol = 1'b0;
            in_r = 8'(i + 10); in_g = 8'(i + 20); in_b = 8'(i + 30);
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0; in_sof = 1'b0;
        n_checks++;
        if (out_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre_vld: got %b, want 1", out_vld);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async_vld: got %b, want 0", out_vld);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_vld !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_stale clock %0d: got out_vld %b, want 0", c, out_vld);
            end
        end
    endtask

`ifdef CLIP_STAT_EN
    task automatic test_clip_stat();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            st_vld[i] = 1;
            st_sof[i] = (i == 0) || (i == 16);
            st_eol[i] = 0;
            st_byp[i] = 0;
            st_r[i] = 8'd200; st_g[i] = 8'd100; st_b[i] = 8'd50;
            st_gain[i] = (i == 2 || i == 5 || i == 7 || i == 11 || i == 15) ? 9'd511 : 9'd256;
        end
        run_stream(17);
        n_checks++;
        if ({ob_fcv[1], ob_fcc[1]} !== {1'b1, 22'd0}) begin
            n_fail++;
            $display("FAIL clipstat_first: got vld=%b cnt=%0d, want 1 0", ob_fcv[1], ob_fcc[1]);
        end
        n_checks++;
        if ({ob_fcv[17], ob_fcc[17]} !== {1'b1, 22'd5}) begin
            n_fail++;
            $display("FAIL clipstat_frame: got vld=%b cnt=%0d, want 1 5", ob_fcv[17], ob_fcc[17]);
        end
        for (int j = 0; j < 20; j++) pulses += int'(ob_fcv[j]);
        n_checks++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL clipstat_pulses: got %0d pulses, want 2", pulses);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_unity();
        test_rounding();
        test_saturation();
        test_stream_gaps();
        test_random();
        test_reset_midstream();
`ifdef CLIP_STAT_EN
        test_clip_stat();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
